// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e        : operation encodings presented on the Op input
//   state_e     : sequencer state encoding
//   ITER_COUNT  : number of one-bit iterations per MULT/DIV
//   DIV0_QUOT   : quotient produced by a divide by zero
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply/divide datapath (combinational).
// Optional feature macro: MULDIV_DIV_EN adds the restoring-division step.
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//              (port exists only with MULDIV_DIV_EN)
//   hi, lo   : current accumulator halves
//   operand  : multiplicand magnitude or divisor magnitude
//   hi_nxt, lo_nxt : accumulator after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  // Multiply: lo holds the remaining multiplier bits; add the multiplicand
  // into hi when the current LSB is set, then shift {carry,hi,lo} right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);

`ifdef MULDIV_DIV_EN
  // Divide: hi is the partial remainder, lo shifts dividend bits out and
  // quotient bits in. Bit WIDTH of the difference is the borrow.
  logic [WIDTH:0] div_tmp;
  logic [WIDTH:0] div_diff;
  logic           borrow;
  assign div_tmp  = {hi, lo[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, operand};
  assign borrow   = div_diff[WIDTH];

  always_comb begin
    hi_nxt = mul_sum[WIDTH:1];
    lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    if (div_mode) begin
      hi_nxt = borrow ? div_tmp[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~borrow};
    end
  end
`else
  always_comb begin
    hi_nxt = mul_sum[WIDTH:1];
    lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Optional feature macro: MULDIV_DIV_EN enables DIV/DIVU; without it those
// opcodes are no-ops and no divider logic is built.
//   Clk, Rst_n : clock, synchronous active-low reset
//   OpA, OpB   : operands (latched when an operation is accepted)
//   Op         : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   Start      : request, sampled only while idle
//   Busy       : high while a MULT/DIV is in progress
//   Done       : one-cycle pulse when a MULT/DIV result lands in Hi/Lo
//   Hi, Lo     : architectural HI/LO registers
import muldiv_pkg::*;

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [2:0]       Op,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [4:0] CNT_LAST = 5'(ITER_COUNT - 1);

  state_e           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic             neg_res;   // product or quotient must be negated in FIX
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef MULDIV_DIV_EN
  logic             is_div;
  logic             neg_rem;   // remainder follows the dividend's sign
  logic             div_zero;
`endif

  // Magnitude of a value, interpreted as signed only for signed ops.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  assign prod_neg = ~{acc_hi, acc_lo} + (2*WIDTH)'(1);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .hi       (acc_hi),
    .lo       (acc_lo),
    .operand  (operand),
    .hi_nxt   (step_hi),
    .lo_nxt   (step_lo)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      neg_res  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            case (op_e'(Op))
              OP_MULT, OP_MULTU: begin
                state   <= S_CALC;
                Busy    <= 1'b1;
                cnt     <= '0;
                acc_hi  <= '0;
                acc_lo  <= mag(OpA, Op == OP_MULT);
                operand <= mag(OpB, Op == OP_MULT);
                neg_res <= (Op == OP_MULT) && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                is_div  <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                state    <= S_CALC;
                Busy     <= 1'b1;
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= mag(OpA, Op == OP_DIV);
                operand  <= mag(OpB, Op == OP_DIV);
                neg_res  <= (Op == OP_DIV) && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                neg_rem  <= (Op == OP_DIV) && OpA[WIDTH-1];
                div_zero <= (OpB == '0);
                is_div   <= 1'b1;
              end
`endif
              OP_MTHI: Hi <= OpA;
              OP_MTLO: Lo <= OpA;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          // Magnitude result is complete; apply sign corrections.
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            if (div_zero)     acc_lo <= DIV0_QUOT;
            else if (neg_res) acc_lo <= neg(acc_lo);
            if (neg_rem)      acc_hi <= neg(acc_hi);
          end else
`endif
          if (neg_res) {acc_hi, acc_lo} <= prod_neg;
          state <= S_DONE;
        end
        S_DONE: begin
          Hi    <= acc_hi;
          Lo    <= acc_lo;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// MULT/DIV traffic compared against an arithmetic reference model.
// Honors MULDIV_DIV_EN the same way the design does.
module tb_mul_div_unit;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] OpA, OpB;
  logic [2:0]  Op;
  logic        Start;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_hi, exp_lo;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .OpA   (OpA),
    .OpB   (OpB),
    .Op    (Op),
    .Start (Start),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference result {hi,lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {exp_hi, exp_lo};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Full MULT/DIV transaction with junk (including an MTHI at cycle 5)
  // driven while busy; checks timing, stability and final result.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    int busy_cnt, done_cnt;
    logic stable;
    res = model(op, a, b);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    tick();
    busy_cnt = Busy ? 1 : 0;
    done_cnt = Done ? 1 : 0;
    stable = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      Start = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      Op    = (i == 5) ? 3'd4 : 3'($urandom_range(0, 7));
      OpA   = $urandom;
      OpB   = $urandom;
      tick();
      if (i < 34) begin
        if (Busy) busy_cnt++;
        if (Done) done_cnt++;
        if (Hi !== exp_hi || Lo !== exp_lo) stable = 1'b0;
      end
    end
    Start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd34);
    chk({tag, " early_done"}, 64'(done_cnt), 64'd0);
    chk({tag, " hilo_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, " done"}, {62'd0, Done, Busy}, 64'd2);
    chk({tag, " result"}, {Hi, Lo}, res);
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    tick();
    chk({tag, " done_pulse"}, {62'd0, Done, Busy}, 64'd0);
  endtask

  // Single-cycle request that must not start a sequence (MTHI/MTLO/reserved).
  task automatic run_quick(input string tag, input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; OpA = a; OpB = $urandom;
    tick();
    Start = 1'b0;
    if (op == 3'd4) exp_hi = a;
    if (op == 3'd5) exp_lo = a;
    chk({tag, " hilo"}, {Hi, Lo}, {exp_hi, exp_lo});
    chk({tag, " busy_done"}, {62'd0, Busy, Done}, 64'd0);
    tick();
    chk({tag, " idle"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    int done_seen;
    Rst_n = 1'b0; Start = 1'b0; Op = '0; OpA = '0; OpB = '0;
    exp_hi = '0; exp_lo = '0;
    tick(); tick();
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    chk("reset_ctrl", {62'd0, Busy, Done}, 64'd0);
    Rst_n = 1'b1;
    tick();

    run_quick("mthi", 3'd4, 32'h1234_5678);
    run_quick("mtlo", 3'd5, 32'h9ABC_DEF0);
    run_quick("rsv6", 3'd6, 32'hDEAD_BEEF);
    run_quick("rsv7", 3'd7, 32'hCAFE_F00D);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0);
    chk("divu_zero_const", {Hi, Lo}, {32'd100, 32'hFFFF_FFFF});
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {Hi, Lo}, {32'd0, 32'h8000_0000});
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
`else
    run_quick("div_off", 3'd2, 32'h0000_0064);
    run_quick("divu_off", 3'd3, 32'h0000_0064);
`endif

    for (int k = 0; k < 30; k++) begin
`ifdef MULDIV_DIV_EN
      run_op("rand", 3'($urandom_range(0, 3)), pick(), pick());
`else
      run_op("rand", 3'($urandom_range(0, 1)), pick(), pick());
`endif
    end

    // Reset in the middle of a multiply aborts it without a Done pulse.
    run_quick("pre_rst_hi", 3'd4, 32'h5555_AAAA);
    run_quick("pre_rst_lo", 3'd5, 32'hAAAA_5555);
    Start = 1'b1; Op = 3'd0; OpA = 32'h0000_1234; OpB = 32'h0000_5678;
    tick();
    Start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("mid_busy", {63'd0, Busy}, 64'd1);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    chk("abort_ctrl", {62'd0, Busy, Done}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done || Busy) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_hilo_hold", {Hi, Lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  synchronous, active-low reset.
REQ-004 OpA  input  WIDTH  first operand, from register file read port 1.
REQ-005 OpB  input  WIDTH  second operand, from the ALU-source select mux output.
REQ-006 Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved, treated as no-op.
REQ-007 Start  input  1  request; sampled only when Busy=0.
REQ-008 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 Done  output  1  one-cycle pulse when a MULT/DIV result is written to Hi/Lo.
REQ-010 Hi  output  WIDTH  HI register, registered.
REQ-011 Lo  output  WIDTH  LO register, registered.

Function
REQ-012 States SHALL be IDLE, CALC, FIX and DONE.
- IDLE->CALC on Start with a MULT/DIV op.
- CALC->FIX after exactly 32 CALC cycles, counted by a 5-bit iteration counter.
- FIX->DONE, then DONE->IDLE.
REQ-013 Latency: for Start sampled at edge N, Hi/Lo SHALL update and Done SHALL be high at edge N+34; Busy SHALL be high from edge N+1 through edge N+34 inclusive.
REQ-014 Operands SHALL be latched at acceptance; input changes during Busy SHALL have no effect.
REQ-015 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-016 MULT/MULTU: shift-add, one bit per cycle; the 64-bit product is written as {Hi,Lo}.
REQ-017 DIV/DIVU: restoring division, one bit per cycle; Lo=quotient, Hi=remainder.
REQ-018 Signed ops: magnitudes are taken at acceptance and signs are corrected in FIX.
- Product is negative iff the operand signs differ.
- Quotient sign = sign(OpA) XOR sign(OpB).
- Remainder takes the dividend's sign.
REQ-019 Divide by zero SHALL complete with normal latency: Lo=32'hFFFF_FFFF, Hi=dividend.
REQ-020 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give Lo=32'h8000_0000, Hi=0.
REQ-021 MTHI/MTLO with Start in IDLE SHALL write OpA to Hi/Lo at the next edge; no Busy, no Done.
REQ-022 MTHI/MTLO with Start while Busy SHALL be ignored.
REQ-023 Reserved Op with Start SHALL leave the state and outputs unchanged.
REQ-024 Hi/Lo SHALL be stable between writes.

Reset
REQ-025 Rst_n=0 at an edge SHALL force: state=IDLE, counter=0, Busy=0, Done=0, Hi=0, Lo=0, internal operand/accumulator registers=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation at that edge, with no Done pulse and no partial Hi/Lo write.

Configuration
REQ-027 With MULDIV_DIV_EN defined, DIV and DIVU SHALL be implemented as specified.
REQ-028 Without MULDIV_DIV_EN:
- DIV and DIVU SHALL be treated as reserved no-ops, with no Busy and no Done.
- Divider datapath logic SHALL be absent.
- Multiply and MTHI/MTLO behaviour SHALL be unchanged.

Structure
REQ-029 Package muldiv_pkg SHALL hold the Op encodings, the FSM state encoding, the iteration count constant (32) and the divide-by-zero quotient constant.
REQ-030 The one-bit-per-cycle datapath step (add/subtract-and-shift, both modes) SHALL be a sub-module named muldiv_step.
REQ-031 mul_div_unit SHALL contain the FSM, counter, sign handling and the Hi/Lo registers.

Verification
REQ-032 MULTU with OpA=32'hFFFF_FFFF, OpB=32'hFFFF_FFFF -> at N+34: Hi=32'hFFFF_FFFE, Lo=32'h0000_0001, Done one cycle, Busy high for 34 cycles.
REQ-033 MULT with OpA=-3 (32'hFFFF_FFFD), OpB=7 -> Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB.
REQ-034 DIV with OpA=-7, OpB=2 -> Lo=32'hFFFF_FFFD, Hi=32'hFFFF_FFFF.
REQ-035 DIVU with OpA=100, OpB=0 -> Lo=32'hFFFF_FFFF, Hi=100.
REQ-036 MULT started, Rst_n=0 at cycle 10 -> Hi=Lo=0, Busy=0, no Done.
REQ-037 MULT started, then Start with MTHI at cycle 5 -> Hi unaffected by the MTHI.
REQ-038 Without MULDIV_DIV_EN: DIV with Start -> Busy stays 0, Hi/Lo unchanged.
